// File: rtl/full_axi_lite_regbank.sv
// AXI4-Lite slave holding NUM_REGS 32-bit registers; write commits one cycle after AW+W are both held, read data registered at AR.
// One outstanding write and one outstanding read; AW/W/AR stall while the matching B or R response waits for its ready.
module full_axi_lite_regbank #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS = 4
) (
  input  logic                               ACLK,
  input  logic                               ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_AWADDR,
  input  logic [2:0]                         S_AXI_AWPROT,
  input  logic                               S_AXI_AWVALID,
  output logic                               S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]    S_AXI_WSTRB,
  input  logic                               S_AXI_WVALID,
  output logic                               S_AXI_WREADY,
  output logic [1:0]                         S_AXI_BRESP,
  output logic                               S_AXI_BVALID,
  input  logic                               S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
  input  logic [2:0]                         S_AXI_ARPROT,
  input  logic                               S_AXI_ARVALID,
  output logic                               S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
  output logic [1:0]                         S_AXI_RRESP,
  output logic                               S_AXI_RVALID,
  input  logic                               S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]                wr_pulse
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
  localparam int NB = DW / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DW-1:0] regs [NUM_REGS];
  logic          aw_held, w_held;
  logic [IW-1:0] aw_idx;
  logic [DW-1:0] w_data;
  logic [NB-1:0] w_strb;
  logic          bvalid, rvalid;
  logic [1:0]    bresp, rresp;
  logic [DW-1:0] rdata, rd_sel;
  logic [NUM_REGS-1:0] pulse;

  logic [IW-1:0] ar_idx;
  logic aw_hs, w_hs, ar_hs, commit, aw_ok, ar_ok;
  logic unused_inputs;

  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Readies are gated by reset so they read 0 while ARESETN is low.
  assign S_AXI_AWREADY = ARESETN & ~aw_held & ~bvalid;
  assign S_AXI_WREADY  = ARESETN & ~w_held & ~bvalid;
  assign S_AXI_ARREADY = ARESETN & ~rvalid;

  assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
  assign commit = aw_held & w_held & ~bvalid;
  assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign aw_ok  = int'(aw_idx) < NUM_REGS;
  assign ar_ok  = int'(ar_idx) < NUM_REGS;

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IW'(i)) rd_sel = regs[i];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
      pulse   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      pulse <= '0;
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= aw_ok ? RESP_OKAY : RESP_SLVERR;
        // Out-of-range indices never match, so they neither write nor pulse.
        for (int i = 0; i < NUM_REGS; i++) begin
          if (aw_idx == IW'(i)) begin
            pulse[i] <= 1'b1;
            for (int b = 0; b < NB; b++) begin
              if (w_strb[b]) regs[i][8*b +: 8] <= w_data[8*b +: 8];
            end
          end
        end
      end else if (bvalid && S_AXI_BREADY) begin
        bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid <= 1'b0;
      rresp  <= RESP_OKAY;
      rdata  <= '0;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rdata  <= ar_ok ? rd_sel : '0;
      rresp  <= ar_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid && S_AXI_RREADY) begin
      rvalid <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[DW*g +: DW] = regs[g];
  end

  assign S_AXI_BVALID = bvalid;
  assign S_AXI_BRESP  = bresp;
  assign S_AXI_RVALID = rvalid;
  assign S_AXI_RRESP  = rresp;
  assign S_AXI_RDATA  = rdata;
  assign wr_pulse     = pulse;

endmodule

// File: tb/tb_full_axi_lite_regbank.sv
// Scoreboard bench for full_axi_lite_regbank: expected B/R responses are queued at stimulus time and popped by a response monitor.
module tb_full_axi_lite_regbank;

  localparam int NR = 4;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  logic [4:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [4:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic [NR*32-1:0] reg_out;
  logic [NR-1:0]    wr_pulse;

  full_axi_lite_regbank #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5),
    .NUM_REGS(NR)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_out(reg_out), .wr_pulse(wr_pulse)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];
  logic [31:0] model [NR];
  int pulse_cnt [NR];
  int exp_pulse [NR];

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    f = '0;
    for (int i = 0; i < NR; i++) f[32*i +: 32] = model[i];
    return f;
  endfunction

  task automatic monitor();
    forever begin
      @(negedge ACLK);
      if (ARESETN) begin
        if (S_AXI_BVALID && S_AXI_BREADY) begin
          if (exp_b.size() == 0) check_val("b_unexpected", 128'(1), '0);
          else check_val("bresp", 128'(S_AXI_BRESP), 128'(exp_b.pop_front()));
        end
        if (S_AXI_RVALID && S_AXI_RREADY) begin
          if (exp_r.size() == 0) check_val("r_unexpected", 128'(1), '0);
          else check_val("rresp_rdata", 128'({S_AXI_RRESP, S_AXI_RDATA}), 128'(exp_r.pop_front()));
        end
        for (int i = 0; i < NR; i++) if (wr_pulse[i]) pulse_cnt[i]++;
      end
    end
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int w_lead, input int b_hold);
    int cyc, idx;
    bit aw_done, w_done, aw_acc, w_acc;
    logic [1:0] eb;
    idx = int'(addr[4:2]);
    eb = (idx < NR) ? 2'b00 : 2'b10;
    exp_b.push_back(eb);
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_WVALID = 1'b1;
    S_AXI_AWVALID = (w_lead == 0);
    cyc = 0; aw_done = 0; w_done = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      @(negedge ACLK);
      if (w_done && !aw_done) begin
        check_val("w_held_wready", 128'(S_AXI_WREADY), '0);
        check_val("w_held_no_bvalid", 128'(S_AXI_BVALID), '0);
      end
      aw_acc = S_AXI_AWVALID && S_AXI_AWREADY;
      w_acc  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK); #1;
      if (aw_acc) begin aw_done = 1; S_AXI_AWVALID = 1'b0; end
      if (w_acc)  begin w_done = 1;  S_AXI_WVALID = 1'b0; end
      cyc++;
      if (!aw_done && cyc >= w_lead) S_AXI_AWVALID = 1'b1;
    end
    if (!(aw_done && w_done)) check_val("aw_w_timeout", '0, 128'(1));
    cyc = 0;
    @(negedge ACLK);
    while (!S_AXI_BVALID && cyc < 20) begin @(negedge ACLK); cyc++; end
    if (!S_AXI_BVALID) check_val("bvalid_timeout", '0, 128'(1));
    if (idx < NR) begin
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
      exp_pulse[idx]++;
    end
    @(posedge ACLK); #1;
    repeat (b_hold) begin
      @(negedge ACLK);
      check_val("bhold_bvalid", 128'(S_AXI_BVALID), 128'(1));
      check_val("bhold_bresp", 128'(S_AXI_BRESP), 128'(eb));
      check_val("bhold_awready", 128'(S_AXI_AWREADY), '0);
      check_val("bhold_wready", 128'(S_AXI_WREADY), '0);
      @(posedge ACLK); #1;
    end
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    @(negedge ACLK);
    check_val("ready_after_b", 128'({S_AXI_AWREADY, S_AXI_WREADY}), 128'(2'b11));
    for (int i = 0; i < NR; i++) check_val($sformatf("pulse_cnt%0d", i), 128'(pulse_cnt[i]), 128'(exp_pulse[i]));
    check_val("reg_out", reg_out, model_flat());
    @(posedge ACLK); #1;
  endtask

  task automatic axi_read(input logic [4:0] addr, input int r_hold);
    int cyc, idx;
    bit acc, done;
    logic [33:0] er;
    idx = int'(addr[4:2]);
    if (idx < NR) er = {2'b00, model[idx]};
    else er = {2'b10, 32'h0};
    exp_r.push_back(er);
    S_AXI_ARADDR = addr;
    S_AXI_ARVALID = 1'b1;
    cyc = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge ACLK);
      acc = S_AXI_ARVALID && S_AXI_ARREADY;
      @(posedge ACLK); #1;
      if (acc) begin done = 1; S_AXI_ARVALID = 1'b0; end
      cyc++;
    end
    if (!done) check_val("ar_timeout", '0, 128'(1));
    cyc = 0;
    @(negedge ACLK);
    while (!S_AXI_RVALID && cyc < 20) begin @(negedge ACLK); cyc++; end
    if (!S_AXI_RVALID) check_val("rvalid_timeout", '0, 128'(1));
    @(posedge ACLK); #1;
    repeat (r_hold) begin
      @(negedge ACLK);
      check_val("rhold_rvalid", 128'(S_AXI_RVALID), 128'(1));
      check_val("rhold_rdata", 128'({S_AXI_RRESP, S_AXI_RDATA}), 128'(er));
      check_val("rhold_arready", 128'(S_AXI_ARREADY), '0);
      @(posedge ACLK); #1;
    end
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin model[i] = '0; pulse_cnt[i] = 0; exp_pulse[i] = 0; end
    fork
      monitor();
    join_none

    repeat (3) @(posedge ACLK);
    #1;
    check_val("rst_readies", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), '0);
    check_val("rst_valids", 128'({S_AXI_BVALID, S_AXI_RVALID}), '0);
    check_val("rst_resp_data", 128'({S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}), '0);
    check_val("rst_reg_out", reg_out, '0);
    check_val("rst_wr_pulse", 128'(wr_pulse), '0);
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    check_val("post_rst_readies", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(3'b111));

    // sequential writes then readback
    for (int i = 0; i < NR; i++) axi_write(5'(4*i), 32'(i + 1), 4'hF, 0, 0);
    for (int i = 0; i < NR; i++) axi_read(5'(4*i), 0);

    // byte strobes
    axi_write(5'h04, 32'hAABBCCDD, 4'hF, 0, 0);
    axi_write(5'h04, 32'h11223344, 4'h5, 0, 0);
    axi_read(5'h04, 0);
    check_val("strobe_model", 128'(model[1]), 128'(32'hAA22CC44));

    // out of range
    axi_write(5'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    axi_read(5'h14, 0);

    // zero strobe still pulses, addr[1:0] ignored
    axi_write(5'h0F, 32'hFFFFFFFF, 4'h0, 0, 0);

    // channel ordering and backpressure
    axi_write(5'h0C, 32'hCAFEF00D, 4'hF, 3, 0);
    axi_write(5'h00, 32'h12345678, 4'hF, 0, 5);
    axi_write(5'h1C, 32'h0BADF00D, 4'hF, 0, 3);
    axi_read(5'h0C, 4);
    axi_read(5'h18, 2);

    // read and write commit landing on the same edge
    axi_write(5'h08, 32'h00000003, 4'hF, 0, 0);
    fork
      axi_write(5'h08, 32'h00000055, 4'hF, 0, 0);
      begin
        @(posedge ACLK); #1;
        axi_read(5'h08, 0);
      end
    join
    axi_read(5'h08, 0);

    // reset after AW handshake, before W
    S_AXI_AWADDR = 5'h08;
    S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    check_val("aw_ready_pre_rst", 128'(S_AXI_AWREADY), 128'(1));
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    @(negedge ACLK); #2;
    ARESETN = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    check_val("midrst_reg_out", reg_out, '0);
    check_val("midrst_bvalid", 128'(S_AXI_BVALID), '0);
    @(posedge ACLK); @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    axi_write(5'h00, 32'h00000077, 4'hF, 5, 0);
    axi_read(5'h08, 0);
    axi_read(5'h00, 0);

    repeat (3) @(posedge ACLK);
    check_val("b_queue_empty", 128'(exp_b.size()), '0);
    check_val("r_queue_empty", 128'(exp_r.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
